// File: rtl/exibe_sequencia.sv
// rtl/exibe_sequencia.sv - presents the stored memory-game sequence on the LEDs
module exibe_sequencia #(
  parameter int TEMPO_LIGADO  = 1000,
  parameter int TEMPO_APAGADO = 500
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_iniciar,
  input  logic [3:0] i_limite,
  output logic [3:0] o_rom_endereco,
  input  logic [3:0] i_rom_dado,
  output logic [3:0] o_leds,
  output logic       o_exibindo,
  output logic       o_pronto,
  output logic [3:0] o_db_estado
);

  // Timer only has to reach the larger of the two phase lengths minus one.
  localparam int TMAX = (TEMPO_LIGADO > TEMPO_APAGADO) ? TEMPO_LIGADO : TEMPO_APAGADO;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] LIGADO_FIM  = TW'(TEMPO_LIGADO - 1);
  localparam logic [TW-1:0] APAGADO_FIM = TW'(TEMPO_APAGADO - 1);

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    BUSCA   = 4'h1,
    CARREGA = 4'h2,
    LIGA    = 4'h3,
    APAGA   = 4'h4,
    FIM     = 4'hF
  } estado_t;

  estado_t       r_estado;
  logic [3:0]    r_endereco;
  logic [3:0]    r_limite;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_leds;
  logic          r_exibindo;
  logic          r_pronto;

  // Sequencer: walks addresses 0..limite, each item lit then blanked; all outputs registered.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_estado   <= INICIAL;
      r_endereco <= 4'd0;
      r_limite   <= 4'd0;
      r_timer    <= '0;
      r_leds     <= 4'd0;
      r_exibindo <= 1'b0;
      r_pronto   <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      case (r_estado)
        INICIAL: begin
          if (i_iniciar) begin
            r_endereco <= 4'd0;
            r_limite   <= i_limite;
            r_exibindo <= 1'b1;
            r_estado   <= BUSCA;
          end
        end
        // ROM captures the stable address at the end of this cycle.
        BUSCA: r_estado <= CARREGA;
        CARREGA: begin
          r_leds   <= i_rom_dado;
          r_timer  <= '0;
          r_estado <= LIGA;
        end
        LIGA: begin
          if (r_timer == LIGADO_FIM) begin
            r_timer  <= '0;
            r_leds   <= 4'd0;
            r_estado <= APAGA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        APAGA: begin
          if (r_timer == APAGADO_FIM) begin
            r_timer <= '0;
            if (r_endereco == r_limite) begin
              r_exibindo <= 1'b0;
              r_pronto   <= 1'b1;
              r_estado   <= FIM;
            end else begin
              r_endereco <= r_endereco + 4'd1;
              r_estado   <= BUSCA;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        FIM:     r_estado <= INICIAL;
        default: r_estado <= INICIAL;
      endcase
    end
  end

  assign o_rom_endereco = r_endereco;
  assign o_leds         = r_leds;
  assign o_exibindo     = r_exibindo;
  assign o_pronto       = r_pronto;
  assign o_db_estado    = r_estado;

endmodule
